accum_alu_seq: RTL and testbench
================================

# accum_alu_seq

Parametrised accumulator ALU: the lab-series registered ALU generalised to DATA_W-bit operands and a 2*DATA_W-bit accumulator, with eight functions, a multi-cycle shift-add multiplier and a Start/Busy/Done handshake. Operand A is the Data input; operand B is the low DATA_W bits of the current accumulator, so results chain from one op to the next. It sits between the switch/key input stage and the hex display drivers.

## Interface
- DATA_W, default 4: operand width (≥2); accumulator/ALUout width is 2*DATA_W.
- Clock  in  1  system clock, rising edge.
- Reset_b  in  1  asynchronous, active-high reset.
- Data  in  DATA_W  operand A.
- Function  in  3  opcode, sampled with Start.
- Start  in  1  issue request; honoured only while Busy=0.
- Busy  out  1  high while a multiply is in progress.
- Done  out  1  one-cycle pulse: ALUout holds a newly completed result.
- Borrow  out  1  registered; 1 iff last completed op was SUB with Data < B.
- Zero  out  1  combinational: ALUout == 0.
- ALUout  out  2*DATA_W  accumulator register.

## Operation
- B = ALUout[DATA_W-1:0]; operands zero-extended to 2*DATA_W; all results truncated to 2*DATA_W (modulo 2^(2*DATA_W)).
- 000 ADD: Data + B.
- 001 SUB: Data - B, two's-complement wrap; Borrow = (Data < B).
- 010 MUL: Data * B, sequential shift-add, one multiplier bit per cycle.
- 011 SHL: B << Data; Data ≥ 2*DATA_W gives 0.
- 100 SHR: ALUout >> Data (logical, full accumulator); Data ≥ 2*DATA_W gives 0.
- 101 AND: Data & B.
- 110 LOAD: Data.
- 111 HOLD: ALUout unchanged; still completes and pulses Done.
- Borrow updated on every completed op (0 for all ops except SUB with Data < B); unchanged otherwise.
- FSM states: IDLE, MUL.
  - IDLE, Start=1, Function≠010: write result to ALUout, Done=1, stay IDLE.
  - IDLE, Start=1, Function=010: latch Data and B into internal operand registers, clear partial product, load iteration counter with DATA_W-1, go MUL.
  - MUL: add shifted multiplicand if current multiplier bit is 1, decrement counter. When counter=0 that cycle: write product to ALUout, Done=1, go IDLE.
  - IDLE, Start=0: nothing changes; Done=0.
- Start, Data and Function are ignored while Busy=1; no queuing, and the dropped request is never executed.
- ALUout does not change during MUL; the product appears only at completion.

## Timing
- Reset (asynchronous, immediate, independent of Clock): ALUout=0, Borrow=0, Done=0, Busy=0, FSM=IDLE, counter/operand registers=0; Zero=1.
- Reset asserted mid-multiply aborts the op; no Done is produced for it.
- First edge after Reset_b deasserts may accept a Start.
- Single-cycle ops: Start sampled at edge k; ALUout/Borrow/Done valid after edge k; Done low after edge k+1 unless a new op completes.
- Back-to-back single-cycle ops: one per cycle, each using the ALUout from the previous edge as B.
- MUL: Start at edge k; Busy=1 after edge k through edge k+DATA_W-1; after edge k+DATA_W: ALUout=product, Done=1, Busy=0. Total latency DATA_W cycles.
- Start at the same edge Busy falls is not accepted; the first acceptable Start edge is k+DATA_W+1.
- Busy and Done are never high in the same cycle.

## Test plan
(DATA_W=4 unless stated)
- Reset, then ADD Data=5 → ALUout=0x05, Done high for exactly 1 cycle, Busy=0, Zero=0.
- ALUout=0x05, MUL Data=7 → Busy high 4 cycles; ALUout stays 0x05 throughout; then ALUout=0x23 with Done; Start pulsed mid-Busy has no effect.
- ALUout=0x23: SHL Data=2 → 0x0C; then LOAD 3 and SHL Data=9 → 0x00, Zero=1.
- ALUout=0x0C: SUB Data=3 → 0xF7, Borrow=1; then ADD Data=1 → 0x08, Borrow=0.
- ALUout=0xF7: SHR Data=4 → 0x0F; then HOLD → 0x0F with a Done pulse; then AND Data=0x6 → 0x06.
- Reset asserted 2 cycles into a MUL → ALUout=0 and Busy=0 before the next edge, no Done; repeat the MUL with DATA_W=8 (B=0xFF, Data=0xFF) → 0xFE01 after 8 cycles.

Source files
------------

// File: rtl/accum_alu_seq_if.sv
// Request/response bundle between the input stage and the accumulator ALU.
interface accum_alu_seq_if #(
  parameter int unsigned DATA_W = 4
);
  localparam int unsigned ACC_W = 2 * DATA_W;

  logic [DATA_W-1:0] Data;
  logic [2:0]        Function;
  logic              Start;
  logic              Busy;
  logic              Done;
  logic              Borrow;
  logic              Zero;
  logic [ACC_W-1:0]  ALUout;

  modport slave  (input  Data, Function, Start,
                  output Busy, Done, Borrow, Zero, ALUout);
  modport master (output Data, Function, Start,
                  input  Busy, Done, Borrow, Zero, ALUout);
endinterface

// File: rtl/accum_alu_seq.sv
// Accumulator ALU: operand A from the bus, operand B from the low half of the
// accumulator; single-cycle ops plus a sequential shift-add multiplier.
module accum_alu_seq #(
  parameter int unsigned DATA_W = 4
) (
  input  logic            Clock,
  input  logic            Reset_b,
  accum_alu_seq_if.slave  bus
);
  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_HOLD = 3'b111;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc,    w_acc_nxt;
  logic [ACC_W-1:0]   r_mcand,  w_mcand_nxt;
  logic [ACC_W-1:0]   r_prod,   w_prod_nxt;
  logic [DATA_W-1:0]  r_mplier, w_mplier_nxt;
  logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
  logic               r_busy,   w_busy_nxt;
  logic               r_done,   w_done_nxt;
  logic               r_borrow, w_borrow_nxt;

  logic [DATA_W-1:0]  w_b;
  logic [ACC_W-1:0]   w_a_ext, w_b_ext;
  logic               w_shift_big;
  logic [ACC_W-1:0]   w_alu_res;
  logic               w_alu_borrow;
  logic [ACC_W-1:0]   w_prod_add;

  assign w_b         = r_acc[DATA_W-1:0];
  assign w_a_ext     = ACC_W'(bus.Data);
  assign w_b_ext     = ACC_W'(w_b);
  assign w_shift_big = (w_a_ext >= ACC_W'(ACC_W));
  assign w_prod_add  = r_prod + (r_mplier[0] ? r_mcand : '0);

  // Single-cycle function result, computed from the current accumulator
  always_comb begin
    w_alu_res    = r_acc;
    w_alu_borrow = 1'b0;
    case (bus.Function)
      OP_ADD:  w_alu_res = w_a_ext + w_b_ext;
      OP_SUB: begin
        w_alu_res    = w_a_ext - w_b_ext;
        w_alu_borrow = (bus.Data < w_b);
      end
      OP_SHL:  w_alu_res = w_shift_big ? '0 : (w_b_ext << bus.Data);
      OP_SHR:  w_alu_res = w_shift_big ? '0 : (r_acc >> bus.Data);
      OP_AND:  w_alu_res = w_a_ext & w_b_ext;
      OP_LOAD: w_alu_res = w_a_ext;
      OP_HOLD: w_alu_res = r_acc;
      default: w_alu_res = r_acc;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.Start && (bus.Function == OP_MUL)) w_state_nxt = S_MUL;
      S_MUL:   if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values; requests arriving during MUL are dropped
  always_comb begin
    w_acc_nxt    = r_acc;
    w_borrow_nxt = r_borrow;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = 1'b0;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_prod_nxt   = r_prod;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          if (bus.Function == OP_MUL) begin
            w_mcand_nxt  = w_a_ext;
            w_mplier_nxt = w_b;
            w_prod_nxt   = '0;
            w_cnt_nxt    = CNT_W'(DATA_W - 1);
            w_busy_nxt   = 1'b1;
          end else begin
            w_acc_nxt    = w_alu_res;
            w_borrow_nxt = w_alu_borrow;
            w_done_nxt   = 1'b1;
          end
        end
      end
      S_MUL: begin
        w_prod_nxt   = w_prod_add;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt - CNT_W'(1);
        if (r_cnt == '0) begin
          w_acc_nxt    = w_prod_add;
          w_borrow_nxt = 1'b0;
          w_done_nxt   = 1'b1;
        end else begin
          w_busy_nxt   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) begin
      r_acc    <= '0;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      r_acc    <= w_acc_nxt;
      r_borrow <= w_borrow_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_prod   <= w_prod_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.ALUout = r_acc;
  assign bus.Busy   = r_busy;
  assign bus.Done   = r_done;
  assign bus.Borrow = r_borrow;
  assign bus.Zero   = (r_acc == '0);

endmodule

// File: tb/tb_accum_alu_seq.sv
// Bench for accum_alu_seq: directed vector table, scoreboarded random ops,
// multiply handshake corners, reset abort and an 8-bit multiply.
module tb_accum_alu_seq;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_LOAD = 3'd6;
  localparam logic [2:0] OP_HOLD = 3'd7;
  localparam int NV = 21;

  typedef struct {
    logic [2:0] f;
    logic [3:0] d;
    logic [7:0] acc;
    logic       b;
  } vec_t;

  typedef struct {
    logic [7:0] acc;
    logic       b;
  } exp_t;

  logic clk = 1'b0;
  logic rst4, rst8;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [7:0] model_acc;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  accum_alu_seq_if #(.DATA_W(4)) if4 ();
  accum_alu_seq_if #(.DATA_W(8)) if8 ();

  accum_alu_seq #(.DATA_W(4)) dut4 (.Clock(clk), .Reset_b(rst4), .bus(if4));
  accum_alu_seq #(.DATA_W(8)) dut8 (.Clock(clk), .Reset_b(rst8), .bus(if8));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic [2:0] f, input logic [3:0] d,
                                       input logic [7:0] acc);
    logic [7:0] a, b, r;
    logic       br;
    a  = {4'h0, d};
    b  = {4'h0, acc[3:0]};
    br = 1'b0;
    case (f)
      OP_ADD:  r = a + b;
      OP_SUB:  begin r = a - b; br = (a < b); end
      OP_MUL:  r = a * b;
      OP_SHL:  r = (d >= 4'd8) ? 8'h00 : 8'(b << d);
      OP_SHR:  r = (d >= 4'd8) ? 8'h00 : 8'(acc >> d);
      OP_AND:  r = a & b;
      OP_LOAD: r = a;
      default: r = acc;
    endcase
    return {br, r};
  endfunction

  // Drive one request at a falling edge and record its expected completion
  task automatic issue(input logic [2:0] f, input logic [3:0] d,
                       input logic [7:0] eacc, input logic eb, input bit wait_mul);
    exp_t e;
    e.acc = eacc;
    e.b   = eb;
    if4.Start    = 1'b1;
    if4.Function = f;
    if4.Data     = d;
    sb.push_back(e);
    model_acc = eacc;
    @(negedge clk);
    if4.Start = 1'b0;
    if (wait_mul && f == OP_MUL) repeat (4) @(negedge clk);
  endtask

  // Scoreboard monitor on the 4-bit instance
  always @(negedge clk) begin
    if (!rst4) begin
      chk("busy_done_excl", 32'(if4.Busy & if4.Done), 32'd0);
      if (if4.Done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_done: Done high with no pending op at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("aluout", 32'(if4.ALUout), 32'(e.acc));
          chk("borrow", 32'(if4.Borrow), 32'(e.b));
          chk("zero",   32'(if4.Zero),   32'(e.acc == 8'h00));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    logic [8:0] r;
    logic [2:0] f;
    logic [3:0] d;

    vecs[0]  = '{OP_SHL,  4'd2,  8'h0C, 1'b0};
    vecs[1]  = '{OP_LOAD, 4'd3,  8'h03, 1'b0};
    vecs[2]  = '{OP_SHL,  4'd9,  8'h00, 1'b0};
    vecs[3]  = '{OP_LOAD, 4'hC,  8'h0C, 1'b0};
    vecs[4]  = '{OP_SUB,  4'd3,  8'hF7, 1'b1};
    vecs[5]  = '{OP_ADD,  4'd1,  8'h08, 1'b0};
    vecs[6]  = '{OP_LOAD, 4'hC,  8'h0C, 1'b0};
    vecs[7]  = '{OP_SUB,  4'd3,  8'hF7, 1'b1};
    vecs[8]  = '{OP_SHR,  4'd4,  8'h0F, 1'b0};
    vecs[9]  = '{OP_HOLD, 4'd0,  8'h0F, 1'b0};
    vecs[10] = '{OP_AND,  4'd6,  8'h06, 1'b0};
    vecs[11] = '{OP_SUB,  4'd6,  8'h00, 1'b0};
    vecs[12] = '{OP_SUB,  4'd1,  8'h01, 1'b0};
    vecs[13] = '{OP_SUB,  4'd0,  8'hFF, 1'b1};
    vecs[14] = '{OP_HOLD, 4'd5,  8'hFF, 1'b0};
    vecs[15] = '{OP_SHR,  4'd7,  8'h01, 1'b0};
    vecs[16] = '{OP_LOAD, 4'hF,  8'h0F, 1'b0};
    vecs[17] = '{OP_SHL,  4'd7,  8'h80, 1'b0};
    vecs[18] = '{OP_LOAD, 4'hF,  8'h0F, 1'b0};
    vecs[19] = '{OP_ADD,  4'hF,  8'h1E, 1'b0};
    vecs[20] = '{OP_SHR,  4'd8,  8'h00, 1'b0};

    rst4 = 1'b1; rst8 = 1'b1;
    if4.Start = 1'b0; if4.Function = 3'd0; if4.Data = 4'd0;
    if8.Start = 1'b0; if8.Function = 3'd0; if8.Data = 8'd0;
    model_acc = 8'h00;
    repeat (2) @(negedge clk);
    rst4 = 1'b0; rst8 = 1'b0;

    chk("rst_aluout", 32'(if4.ALUout), 32'h0);
    chk("rst_zero",   32'(if4.Zero),   32'd1);
    chk("rst_busy",   32'(if4.Busy),   32'd0);
    chk("rst_done",   32'(if4.Done),   32'd0);
    chk("rst_borrow", 32'(if4.Borrow), 32'd0);

    // ADD right after reset release: accepted on the first edge
    issue(OP_ADD, 4'd5, 8'h05, 1'b0, 1'b0);
    chk("add_done",  32'(if4.Done), 32'd1);
    chk("add_busy",  32'(if4.Busy), 32'd0);
    chk("add_zero",  32'(if4.Zero), 32'd0);
    @(negedge clk);
    chk("add_done_pulse", 32'(if4.Done), 32'd0);

    // MUL 7 x 5 with ignored Starts mid-busy and on the edge Busy falls
    issue(OP_MUL, 4'd7, 8'h23, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("mul_busy",   32'(if4.Busy),   32'd1);
      chk("mul_hold",   32'(if4.ALUout), 32'h05);
      chk("mul_nodone", 32'(if4.Done),   32'd0);
      if (i == 1 || i == 3) begin
        if4.Start = 1'b1; if4.Function = OP_ADD; if4.Data = 4'd1;
      end else begin
        if4.Start = 1'b0;
      end
      @(negedge clk);
    end
    if4.Start = 1'b0;
    chk("mul_busy_fall", 32'(if4.Busy), 32'd0);
    @(negedge clk);
    chk("mul_after_done", 32'(if4.Done),   32'd0);
    chk("mul_after_acc",  32'(if4.ALUout), 32'h23);
    model_acc = 8'h23;

    // Directed back-to-back vectors
    for (int i = 0; i < NV; i++)
      issue(vecs[i].f, vecs[i].d, vecs[i].acc, vecs[i].b, 1'b1);

    // Random ops against the bench model
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      d = 4'($urandom_range(0, 15));
      r = model(f, d, model_acc);
      issue(f, d, r[7:0], r[8], 1'b1);
    end
    repeat (2) @(negedge clk);

    // Reset two cycles into a multiply aborts it without a Done
    issue(OP_LOAD, 4'd5, 8'h05, 1'b0, 1'b1);
    if4.Start = 1'b1; if4.Function = OP_MUL; if4.Data = 4'd3;
    @(negedge clk);
    if4.Start = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", 32'(if4.Busy), 32'd1);
    #2 rst4 = 1'b1;
    #1;
    chk("abort_aluout", 32'(if4.ALUout), 32'h0);
    chk("abort_busy",   32'(if4.Busy),   32'd0);
    chk("abort_done",   32'(if4.Done),   32'd0);
    chk("abort_zero",   32'(if4.Zero),   32'd1);
    @(negedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_nodone", 32'(if4.Done),   32'd0);
      chk("abort_acc",    32'(if4.ALUout), 32'h0);
    end

    // 8-bit multiply 0xFF x 0xFF
    if8.Start = 1'b1; if8.Function = OP_LOAD; if8.Data = 8'hFF;
    @(negedge clk);
    chk("w8_load", 32'(if8.ALUout), 32'h00FF);
    if8.Function = OP_MUL;
    @(negedge clk);
    if8.Start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (if8.Done) break;
      if (if8.Busy) begin
        busy_cnt++;
        chk("w8_hold", 32'(if8.ALUout), 32'h00FF);
      end
      @(negedge clk);
    end
    chk("w8_done",    32'(if8.Done),   32'd1);
    chk("w8_busy",    32'(if8.Busy),   32'd0);
    chk("w8_latency", 32'(busy_cnt),   32'd8);
    chk("w8_product", 32'(if8.ALUout), 32'hFE01);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
